// File: rtl/rv32i_types.sv
// ============================================================================
// rv32i_types : shared cacheline type and cache arbiter state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  typedef logic [255:0] llc_cacheline;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// cache_arbiter : round-robin arbiter muxing icache/dcache onto one memory port
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cache_arbiter
  import rv32i_types::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_pmem_read,
  input  logic         i_pmem_write,
  input  logic [31:0]  i_pmem_address,
  input  llc_cacheline i_pmem_wdata,
  output llc_cacheline i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  llc_cacheline d_pmem_wdata,
  output llc_cacheline d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output llc_cacheline mem_wdata,
  input  llc_cacheline mem_rdata,
  input  logic         mem_resp
);

  arb_state_e   r_state;
  logic         r_prio_d;
  llc_cacheline r_rdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_d;

  assign w_i_req   = i_pmem_read | i_pmem_write;
  assign w_d_req   = d_pmem_read | d_pmem_write;
  assign w_grant_d = w_d_req & (~w_i_req | r_prio_d);

  assign i_pmem_rdata = r_rdata;
  assign d_pmem_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_prio_d    <= D_FIRST;
      r_rdata     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_pmem_resp <= 1'b0;
      d_pmem_resp <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            mem_read    <= d_pmem_read;
            mem_write   <= d_pmem_write;
            mem_address <= d_pmem_address;
            mem_wdata   <= d_pmem_wdata;
            r_state     <= BUSY_D;
          end else if (w_i_req) begin
            mem_read    <= i_pmem_read;
            mem_write   <= i_pmem_write;
            mem_address <= i_pmem_address;
            mem_wdata   <= i_pmem_wdata;
            r_state     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            r_rdata     <= mem_rdata;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            i_pmem_resp <= (r_state == BUSY_I);
            d_pmem_resp <= (r_state == BUSY_D);
            r_state     <= RESP;
          end
        end
        RESP: begin
          // Priority passes to whichever side was not just served.
          r_prio_d    <= i_pmem_resp;
          i_pmem_resp <= 1'b0;
          d_pmem_resp <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
// tb_cache_arbiter : directed self-checking bench for cache_arbiter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_cache_arbiter;
  import rv32i_types::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_pmem_read, i_pmem_write, d_pmem_read, d_pmem_write;
  logic [31:0]  i_pmem_address, d_pmem_address;
  llc_cacheline i_pmem_wdata, d_pmem_wdata, i_pmem_rdata, d_pmem_rdata;
  logic         i_pmem_resp, d_pmem_resp;
  logic         mem_read, mem_write, mem_resp;
  logic [31:0]  mem_address;
  llc_cacheline mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // Observations recorded by the downstream model for each transaction
  bit           s_ok, s_stable, s_memoff;
  int           s_wait;
  logic [31:0]  s_addr;
  logic         s_rd, s_wr, s_ri, s_rdr, s_after;
  llc_cacheline s_wdata, s_rdata;
  llc_cacheline last_line;

  always #5 clk = ~clk;

  cache_arbiter #(.D_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_write(i_pmem_write),
    .i_pmem_address(i_pmem_address), .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Downstream memory + requester handshake: waits for a grant, answers after
  // lat cycles, then drops the strobe of whichever side got the resp.
  task automatic serve(input int lat, input llc_cacheline line);
    s_ok = 0; s_wait = -1; s_stable = 1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) begin s_ok = 1; s_wait = n; break; end
    end
    if (!s_ok) return;
    s_addr = mem_address; s_rd = mem_read; s_wr = mem_write; s_wdata = mem_wdata;
    repeat (lat - 1) begin
      @(posedge clk); #1;
      if (mem_address !== s_addr || mem_read !== s_rd || mem_write !== s_wr ||
          i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) s_stable = 0;
    end
    mem_rdata = line; mem_resp = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    s_ri = i_pmem_resp; s_rdr = d_pmem_resp;
    s_rdata = s_ri ? i_pmem_rdata : d_pmem_rdata;
    s_memoff = !mem_read && !mem_write;
    if (s_ri)  begin i_pmem_read = 0; i_pmem_write = 0; end
    if (s_rdr) begin d_pmem_read = 0; d_pmem_write = 0; end
    @(posedge clk); #1;
    s_after = i_pmem_resp | d_pmem_resp;
    last_line = line;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2 rst = 1'b0; #1;
    tests++; if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 0000", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}); end
    tests++; if (mem_address !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", mem_address); end
    tests++; if (mem_wdata !== '0 || i_pmem_rdata !== '0) begin fails++; $display("FAIL reset_data got %h/%h exp 0", mem_wdata, i_pmem_rdata); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_icache_read();
    llc_cacheline line = {32{8'hA5}};
    i_pmem_address = 32'h0000_0040; i_pmem_read = 1;
    serve(5, line);
    tests++; if (s_ok !== 1'b1 || s_wait !== 0) begin fails++; $display("FAIL ird_latency got ok=%0d wait=%0d exp ok=1 wait=0", s_ok, s_wait); end
    tests++; if (s_addr !== 32'h40 || s_rd !== 1'b1 || s_wr !== 1'b0) begin fails++; $display("FAIL ird_req got a=%h r=%b w=%b exp a=40 r=1 w=0", s_addr, s_rd, s_wr); end
    tests++; if (s_stable !== 1'b1) begin fails++; $display("FAIL ird_hold got %0d exp 1", s_stable); end
    tests++; if (s_ri !== 1'b1 || s_rdr !== 1'b0) begin fails++; $display("FAIL ird_resp got i=%b d=%b exp i=1 d=0", s_ri, s_rdr); end
    tests++; if (s_rdata !== line) begin fails++; $display("FAIL ird_rdata got %h exp %h", s_rdata, line); end
    tests++; if (s_memoff !== 1'b1 || s_after !== 1'b0) begin fails++; $display("FAIL ird_pulse got memoff=%0d after=%b exp 1/0", s_memoff, s_after); end
  endtask

  task automatic test_tie_first();
    d_pmem_address = 32'h100; d_pmem_wdata = {8{32'hD00D_0001}}; d_pmem_write = 1;
    i_pmem_address = 32'h200; i_pmem_read = 1;
    serve(2, {8{32'h1111_2222}});
    tests++; if (s_addr !== 32'h100 || s_wr !== 1'b1 || s_rd !== 1'b0) begin fails++; $display("FAIL tie_first got a=%h r=%b w=%b exp a=100 r=0 w=1", s_addr, s_rd, s_wr); end
    tests++; if (s_wdata !== {8{32'hD00D_0001}}) begin fails++; $display("FAIL tie_wdata got %h exp %h", s_wdata, {8{32'hD00D_0001}}); end
    tests++; if (s_rdr !== 1'b1 || s_ri !== 1'b0 || s_after !== 1'b0) begin fails++; $display("FAIL tie_dresp got d=%b i=%b after=%b exp 1/0/0", s_rdr, s_ri, s_after); end
    serve(3, {8{32'h3333_4444}});
    tests++; if (s_addr !== 32'h200 || s_rd !== 1'b1 || s_wr !== 1'b0) begin fails++; $display("FAIL tie_second got a=%h r=%b w=%b exp a=200 r=1 w=0", s_addr, s_rd, s_wr); end
    tests++; if (s_ri !== 1'b1 || s_rdr !== 1'b0 || s_after !== 1'b0) begin fails++; $display("FAIL tie_iresp got i=%b d=%b after=%b exp 1/0/0", s_ri, s_rdr, s_after); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    d_pmem_address = 32'hA00; d_pmem_read = 1;
    i_pmem_address = 32'hB00; i_pmem_read = 1;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'hA00 : 32'hB00;
      serve(1 + k, {8{32'hC0DE_0000 + k}});
      tests++; if (s_addr !== exp_addr || s_rdr !== (k % 2 == 0)) begin fails++; $display("FAIL rr_grant%0d got a=%h dresp=%b exp a=%h", k, s_addr, s_rdr, exp_addr); end
      if (k < 2) begin
        if (s_rdr) d_pmem_read = 1;
        if (s_ri)  i_pmem_read = 1;
      end
    end
  endtask

  task automatic test_addr_hold();
    bit seen = 0;
    i_pmem_address = 32'h700; i_pmem_read = 1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (mem_read) begin seen = 1; break; end
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL hold_grant got %0d exp 1", seen); end
    i_pmem_address = 32'hDEAD_BEE0; i_pmem_read = 0; i_pmem_write = 1;
    repeat (3) @(posedge clk); #1;
    tests++; if (mem_address !== 32'h700 || mem_read !== 1'b1 || mem_write !== 1'b0) begin fails++; $display("FAIL hold_addr got a=%h r=%b w=%b exp a=700 r=1 w=0", mem_address, mem_read, mem_write); end
    mem_rdata = {8{32'h7777_0000}}; mem_resp = 1;
    @(posedge clk); #1 mem_resp = 0;
    tests++; if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== {8{32'h7777_0000}}) begin fails++; $display("FAIL hold_resp got %b %h exp 1 %h", i_pmem_resp, i_pmem_rdata, {8{32'h7777_0000}}); end
    i_pmem_write = 0; last_line = {8{32'h7777_0000}};
    @(posedge clk); #1;
  endtask

  task automatic test_spurious_resp();
    mem_rdata = {8{32'hBAD0_BAD0}}; mem_resp = 1;
    @(posedge clk); #1 mem_resp = 0;
    tests++; if ({i_pmem_resp, d_pmem_resp, mem_read, mem_write} !== 4'b0) begin fails++; $display("FAIL spur_ctrl got %b exp 0000", {i_pmem_resp, d_pmem_resp, mem_read, mem_write}); end
    tests++; if (d_pmem_rdata !== last_line) begin fails++; $display("FAIL spur_rdata got %h exp %h", d_pmem_rdata, last_line); end
    @(posedge clk); #1;
    tests++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin fails++; $display("FAIL spur_late got i=%b d=%b exp 0/0", i_pmem_resp, d_pmem_resp); end
  endtask

  task automatic test_rw_and_iwrite();
    d_pmem_address = 32'h300; d_pmem_wdata = {8{32'h0BAD_F00D}}; d_pmem_read = 1; d_pmem_write = 1;
    serve(2, {8{32'h5555_AAAA}});
    tests++; if (s_rd !== 1'b1 || s_wr !== 1'b1 || s_addr !== 32'h300 || s_wdata !== {8{32'h0BAD_F00D}}) begin fails++; $display("FAIL rw_both got r=%b w=%b a=%h exp r=1 w=1 a=300", s_rd, s_wr, s_addr); end
    tests++; if (s_rdr !== 1'b1) begin fails++; $display("FAIL rw_resp got %b exp 1", s_rdr); end
    i_pmem_address = 32'h400; i_pmem_wdata = {8{32'h1CAC_4E00}}; i_pmem_write = 1;
    serve(2, {8{32'h6666_0000}});
    tests++; if (s_rd !== 1'b0 || s_wr !== 1'b1 || s_addr !== 32'h400 || s_wdata !== {8{32'h1CAC_4E00}}) begin fails++; $display("FAIL iwr got r=%b w=%b a=%h exp r=0 w=1 a=400", s_rd, s_wr, s_addr); end
    tests++; if (s_ri !== 1'b1 || s_rdr !== 1'b0) begin fails++; $display("FAIL iwr_resp got i=%b d=%b exp 1/0", s_ri, s_rdr); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    d_pmem_address = 32'h500; d_pmem_wdata = {8{32'hFFFF_0000}}; d_pmem_write = 1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (mem_write) begin seen = 1; break; end
    end
    tests++; if (seen !== 1'b1) begin fails++; $display("FAIL rmid_grant got %0d exp 1", seen); end
    #2 rst = 1'b0; #1;
    tests++; if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || mem_address !== 32'h0) begin fails++; $display("FAIL rmid_ctrl got %b a=%h exp 0000 a=0", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, mem_address); end
    tests++; if (mem_wdata !== '0 || d_pmem_rdata !== '0) begin fails++; $display("FAIL rmid_data got %h/%h exp 0", mem_wdata, d_pmem_rdata); end
    d_pmem_write = 0;
    @(posedge clk); #1 rst = 1'b1;
    i_pmem_address = 32'h600; i_pmem_read = 1;
    serve(2, {8{32'h9999_8888}});
    tests++; if (s_addr !== 32'h600 || s_ri !== 1'b1 || s_rdata !== {8{32'h9999_8888}}) begin fails++; $display("FAIL rmid_after got a=%h i=%b exp a=600 i=1", s_addr, s_ri); end
  endtask

  initial begin
    i_pmem_read = 0; i_pmem_write = 0; i_pmem_address = '0; i_pmem_wdata = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_resp = 0; mem_rdata = '0; last_line = '0;
    test_reset();
    test_icache_read();
    test_tie_first();
    test_back_to_back();
    test_addr_hold();
    test_spurious_resp();
    test_rw_and_iwrite();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
